// File: rtl/l2_mem_responder_if.sv
// Line-request bus between an L2 cache channel (master) and its memory responder (slave).
interface l2_mem_responder_if;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  modport master (
    output mem_read,
    output mem_write,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ready
  );

  modport slave (
    input  mem_read,
    input  mem_write,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ready
  );
endinterface

// File: rtl/l2_mem_responder.sv
// Fixed-latency backing memory for one L2 line channel.
// Read data is captured on entry to RESP and held; writes commit on the RESP edge.
module l2_mem_responder #(
  parameter int unsigned LATENCY  = 4,
  parameter int unsigned IDX_BITS = 8
) (
  input  logic              clk,
  input  logic              proc_reset_n,
  l2_mem_responder_if.slave mem,
  output logic              busy,
  output logic [31:0]       rd_done_cnt,
  output logic [31:0]       wr_done_cnt
);
  localparam int unsigned DEPTH    = 1 << IDX_BITS;
  localparam logic [7:0]  CNT_INIT = 8'(LATENCY - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]          state;
  logic [7:0]          cnt;
  logic                lat_write;
  logic [27:0]         lat_addr;
  logic [127:0]        lat_wdata;
  logic [127:0]        rdata_q;
  logic [127:0]        mem_array [DEPTH];

  logic                req_valid;
  logic                req_match;
  logic [IDX_BITS-1:0] req_idx;
  logic [IDX_BITS-1:0] lat_idx;

  assign req_valid = mem.mem_read ^ mem.mem_write;
  assign req_match = req_valid && (mem.mem_write == lat_write) && (mem.mem_addr == lat_addr);
  assign req_idx   = mem.mem_addr[IDX_BITS-1:0];
  assign lat_idx   = lat_addr[IDX_BITS-1:0];

  assign mem.mem_ready = (state == ST_RESP);
  assign mem.mem_rdata = rdata_q;
  assign busy          = (state != ST_IDLE);

  // A request that drops or changes while waiting aborts without side effects.
  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      state       <= ST_IDLE;
      cnt         <= 8'd0;
      lat_write   <= 1'b0;
      lat_addr    <= 28'd0;
      lat_wdata   <= 128'd0;
      rdata_q     <= 128'd0;
      rd_done_cnt <= 32'd0;
      wr_done_cnt <= 32'd0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_array[i] <= 128'd0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            lat_write <= mem.mem_write;
            lat_addr  <= mem.mem_addr;
            lat_wdata <= mem.mem_wdata;
            cnt       <= CNT_INIT;
            if (LATENCY == 1) begin
              state <= ST_RESP;
              if (!mem.mem_write) begin
                rdata_q <= mem_array[req_idx];
              end
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (!req_match) begin
            state <= ST_IDLE;
          end else if (cnt == 8'd1) begin
            state <= ST_RESP;
            if (!lat_write) begin
              rdata_q <= mem_array[lat_idx];
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
          if (lat_write) begin
            mem_array[lat_idx] <= lat_wdata;
            wr_done_cnt        <= wr_done_cnt + 32'd1;
          end else begin
            rd_done_cnt <= rd_done_cnt + 32'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
